// File: rtl/spmv_csr_core.sv
// CSR sparse matrix-vector multiply core: walks row pointers, MACs each
// nonzero against x, and saturates every row sum into a packed result register.
module spmv_csr_core #(
    parameter int N_ROWS  = 16,
    parameter int NNZ_MAX = 64,
    parameter int ADDR_W  = 6,
    parameter int ACC_W   = 40,
    parameter int FRAC    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [(N_ROWS+1)*16-1:0] i_row_ptr,
    input  logic [N_ROWS*16-1:0]     i_in_vector,
    output logic [ADDR_W-1:0]        o_nz_addr,
    output logic                     o_nz_rd_en,
    input  logic [15:0]              i_nz_value,
    input  logic [15:0]              i_nz_col,
    output logic [N_ROWS*16-1:0]     o_register,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int RW = $clog2(N_ROWS + 1);
    localparam int CW = $clog2(N_ROWS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t                   state;
    logic [RW-1:0]            r;
    logic [15:0]              k;
    logic [15:0]              kend;
    logic                     vld;
    logic signed [ACC_W-1:0]  acc;

    logic [15:0]              rp [N_ROWS+1];
    logic signed [15:0]       xv [N_ROWS];
    logic [RW-1:0]            r_nxt;
    logic [15:0]              row_beg;
    logic [15:0]              row_end;
    logic                     row_bad;
    logic                     col_ok;
    logic signed [15:0]       x_sel;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  shifted;
    logic [15:0]              sat;

    always_comb begin
        for (int j = 0; j <= N_ROWS; j++) begin
            rp[j] = i_row_ptr[16*j +: 16];
        end
        for (int j = 0; j < N_ROWS; j++) begin
            xv[j] = i_in_vector[16*j +: 16];
        end
    end

    always_comb begin
        r_nxt   = r + 1'b1;
        row_beg = rp[r];
        row_end = rp[r_nxt];
        row_bad = (row_end < row_beg) || (row_end > 16'(NNZ_MAX));
        col_ok  = i_nz_col < 16'(N_ROWS);
        x_sel   = col_ok ? xv[i_nz_col[CW-1:0]] : '0;
        prod    = 32'(x_sel) * 32'($signed(i_nz_value));
        shifted = acc >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat = 16'h7fff;
        end else if (shifted < SAT_MIN) begin
            sat = 16'h8000;
        end else begin
            sat = shifted[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            r          <= '0;
            k          <= '0;
            kend       <= '0;
            vld        <= 1'b0;
            acc        <= '0;
            o_nz_addr  <= '0;
            o_nz_rd_en <= 1'b0;
            o_register <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            // Read data lags the strobe by one cycle.
            vld <= o_nz_rd_en;
            if (vld) begin
                if (col_ok) begin
                    acc <= acc + ACC_W'(prod);
                end else begin
                    o_err <= 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_ROW;
                        r          <= '0;
                        o_register <= '0;
                        o_err      <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_ROW: begin
                    acc  <= '0;
                    k    <= row_beg + 16'd1;
                    kend <= row_end;
                    if (row_bad) begin
                        o_err <= 1'b1;
                    end
                    if (!row_bad && (row_end > row_beg)) begin
                        o_nz_addr  <= row_beg[ADDR_W-1:0];
                        o_nz_rd_en <= 1'b1;
                        state      <= S_MAC;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MAC: begin
                    // k already points past the address being issued.
                    if (k == kend) begin
                        o_nz_rd_en <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        o_nz_addr <= k[ADDR_W-1:0];
                        k         <= k + 16'd1;
                    end
                end
                S_DRAIN: begin
                    state <= S_WB;
                end
                S_WB: begin
                    o_register[r*16 +: 16] <= sat;
                    if (r == RW'(N_ROWS - 1)) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        r     <= r_nxt;
                        state <= S_ROW;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spmv_csr_core.md
Name: spmv_csr_core

Overview:
- CORE stage of the SpMV engine. Runs after the READ stage has filled the row-pointer, column-index, value and input-vector buffers.
- Walks the CSR structure row by row and multiply-accumulates value × x[col] for every nonzero.
- Saturates each row sum to 16 bits and writes it into the packed 256-bit result register used by the WRITE stage.
- Pulses o_done, which the top FSM uses as core_done.

Parameters:
- N_ROWS, 16: matrix rows and input-vector length; o_register holds N_ROWS×16 bits.
- NNZ_MAX, 64: nonzero buffer depth; valid row_ptr values are 0..NNZ_MAX.
- ADDR_W, 6: nonzero buffer address width.
- ACC_W, 40: signed accumulator width.
- FRAC, 0: arithmetic right shift applied to the accumulator before saturation (fixed-point scaling).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_row_ptr  in  (N_ROWS+1)*16  packed row pointers; entry j at [16j+15:16j]; held stable while o_busy.
- i_in_vector  in  N_ROWS*16  packed signed x vector; entry j at [16j+15:16j]; held stable while o_busy.
- o_nz_addr  out  ADDR_W  nonzero buffer read address.
- o_nz_rd_en  out  1  read strobe; data returns exactly one cycle later.
- i_nz_value  in  16  signed matrix value for the previous cycle's address.
- i_nz_col  in  16  column index for the previous cycle's address.
- o_register  out  N_ROWS*16  signed results; row r at [16r+15:16r].
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error flag; cleared on an accepted start.

Behaviour:
- Reset (asynchronous, i_rstn=0): state=IDLE; o_register=0, o_nz_addr=0, o_nz_rd_en=0, o_busy=0, o_done=0, o_err=0; all counters and the accumulator cleared. Reset asserted mid-operation aborts immediately with the same values.
- States: IDLE, ROW, MAC, DRAIN, WB, DONE.
- IDLE: on i_start=1 go to ROW with row r=0; clear o_register and o_err on the same edge. i_start is ignored in every other state.
- ROW (1 cycle): latch k=row_ptr[r] and end=row_ptr[r+1].
  - If end<k or end>NNZ_MAX: set o_err and treat the row as empty.
  - Clear the accumulator.
  - Go to MAC if the row has nonzeros, otherwise to WB.
- MAC (one cycle per nonzero):
  - Drive o_nz_rd_en=1 and o_nz_addr=k; increment k each cycle. Addresses are back-to-back with no gaps.
  - Go to DRAIN on the cycle that issues address end-1.
  - Each cycle with valid returned data (the cycle after an issue): acc += sign-extended(i_nz_value × x[i_nz_col]), using a signed 16×16→32 product.
  - If i_nz_col ≥ N_ROWS: the product is dropped and o_err is set.
- DRAIN (1 cycle): o_nz_rd_en=0; accumulate the last returned datum; go to WB.
- WB (1 cycle):
  - Compute s = acc >>> FRAC (floor).
  - Saturate s to [-32768, 32767] and write it to row r of o_register.
  - If r=N_ROWS-1 go to DONE; else r+1 and go to ROW.
- DONE (1 cycle): o_done=1, then IDLE. o_busy stays high in DONE.
- Timing:
  - A row with n nonzeros takes n+3 cycles; an empty row takes 2 cycles.
  - o_done is high in cycle T = 1 + Σ(row cycles), counting the first cycle after the accepting edge as cycle 1.
- Storage rules:
  - o_nz_rd_en is never high outside MAC.
  - The accumulator never wraps for NNZ_MAX=64 at ACC_W=40.
  - o_register rows not yet written hold 0; all results hold until the next accepted start.

Test Plan:
- Identity: row_ptr[j]=j, col[j]=j, val[j]=1, x[j]=j+1 -> row j of o_register = j+1; o_done in cycle 65; o_err=0.
- Empty matrix: all row_ptr=0 -> o_register=0; o_nz_rd_en never high; o_done in cycle 33.
- Saturation:
  - Row 0 with two nonzeros 0x7FFF at col 0, x[0]=0x7FFF, other rows empty -> row0=0x7FFF.
  - Values 0x8000 instead -> row0=0x8000.
- Dense row: row 0 has 16 nonzeros at cols 0..15, val=2, x[j]=j, other rows empty -> o_nz_addr 0..15 on 16 consecutive cycles; row0=240; o_done in cycle 50.
- Errors:
  - row_ptr[3]=5, row_ptr[4]=2 -> row3=0, o_err=1.
  - Separate run with a nonzero of col=0x0010 -> that product is dropped and o_err=1.
  - Next start with clean data -> o_err=0.
- Control:
  - i_start pulsed during MAC -> ignored; results unchanged.
  - i_rstn dropped during MAC -> all outputs 0 immediately; a fresh start completes correctly.
